// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between the data port and the fetch port.
// Data normally wins arbitration; fetch is forced through after STARVE_LIM
// consecutive data grants that were taken while fetch was waiting.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    output logic              mem_e,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW    = $clog2(STARVE_LIM + 1);
    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT - 1);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_grant_d;
    logic               w_grant_f;
    logic               w_fetch_wins;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [SW-1:0]      r_starve_cnt;
    logic               r_owner;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_d_rdata;
    logic [DATA_W-1:0]  r_f_rdata;

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign d_rdata   = r_d_rdata;
    assign f_rdata   = r_f_rdata;
    assign owner     = r_owner;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Arbitration, next state, and the state-decoded strobes (enable, acks, busy).
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_f    = 1'b0;
        w_fetch_wins = (r_starve_cnt == STARVE_MAX);
        mem_e        = 1'b0;
        busy         = 1'b0;
        d_ack        = 1'b0;
        f_ack        = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_grant_f = f_req && (!d_req || w_fetch_wins);
                w_grant_d = d_req && !w_grant_f;
                if (w_grant_d || w_grant_f) w_next_state = ACCESS;
            end
            ACCESS: begin
                mem_e = 1'b1;
                busy  = 1'b1;
                if (r_lat_cnt == '0) w_next_state = RESP;
            end
            RESP: begin
                busy         = 1'b1;
                d_ack        = !r_owner;
                f_ack        = r_owner;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Grant latching, latency countdown, read-data capture and starvation tracking.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_owner      <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_d_rdata    <= '0;
            r_f_rdata    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d || w_grant_f) begin
                        r_mem_addr  <= w_grant_f ? f_addr : d_addr;
                        r_mem_we    <= w_grant_d && d_we;
                        r_mem_wdata <= w_grant_d ? d_wdata : '0;
                        r_owner     <= w_grant_f;
                        r_lat_cnt   <= LAT_INIT;
                    end
                    if (w_grant_f) begin
                        r_starve_cnt <= '0;
                    end else if (w_grant_d && f_req && (r_starve_cnt != STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end else begin
                        if (r_owner)        r_f_rdata <= mem_rdata;
                        else if (!r_mem_we) r_d_rdata <= mem_rdata;
                        r_mem_we <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: one instance with single-cycle memory and one
// with three-cycle memory. Completed transactions are checked by a scoreboard
// that pairs each ack pulse with the expectation queued when the request was driven.
module tb_mem_port_arbiter;

    typedef struct {
        logic        isFetch;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] memRdata;
        logic [15:0] expRdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic [15:0] rdata;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        sel;
    logic        d_req, d_we, f_req;
    logic [15:0] d_addr, d_wdata, f_addr, mem_rdata;

    logic        d_ack1, f_ack1, mem_e1, mem_we1, busy1, owner1;
    logic [15:0] d_rdata1, f_rdata1, mem_addr1, mem_wdata1;
    logic        d_ack3, f_ack3, mem_e3, mem_we3, busy3, owner3;
    logic [15:0] d_rdata3, f_rdata3, mem_addr3, mem_wdata3;

    logic        sd_ack, sf_ack, smem_e, smem_we, sbusy, sowner;
    logic [15:0] sd_rdata, sf_rdata, smem_addr, smem_wdata;

    int          nVectors = 0;
    int          nMiscompares = 0;
    sb_t         sbQueue[$];
    sb_t         sbEntry;
    vec_t        vecs[6];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_LIM(4)) u_dut1 (
        .clk(clk), .rst_b(rst1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack1), .f_rdata(f_rdata1),
        .mem_e(mem_e1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata), .busy(busy1), .owner(owner1)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_LIM(4)) u_dut3 (
        .clk(clk), .rst_b(rst3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack3), .f_rdata(f_rdata3),
        .mem_e(mem_e3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata), .busy(busy3), .owner(owner3)
    );

    assign sd_ack     = sel ? d_ack3     : d_ack1;
    assign sf_ack     = sel ? f_ack3     : f_ack1;
    assign smem_e     = sel ? mem_e3     : mem_e1;
    assign smem_we    = sel ? mem_we3    : mem_we1;
    assign sbusy      = sel ? busy3      : busy1;
    assign sowner     = sel ? owner3     : owner1;
    assign sd_rdata   = sel ? d_rdata3   : d_rdata1;
    assign sf_rdata   = sel ? f_rdata3   : f_rdata1;
    assign smem_addr  = sel ? mem_addr3  : mem_addr1;
    assign smem_wdata = sel ? mem_wdata3 : mem_wdata1;

    // Single comparison point: every check counts as one applied vector.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each ack pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (sd_ack || sf_ack) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sb_unexpected_ack", {30'd0, sd_ack, sf_ack}, 32'd0);
            end else begin
                sbEntry = sbQueue.pop_front();
                checkOutput("sb_ack_port", {30'd0, sd_ack, sf_ack},
                            sbEntry.port ? 32'd1 : 32'd2);
                checkOutput("sb_rdata", sbEntry.port ? sf_rdata : sd_rdata, {16'd0, sbEntry.rdata});
            end
        end
    end

    // Hold both instances in reset, then release only the one under test.
    task automatic resetDut(input logic which);
        sel = which;
        rst1 = 1'b0; rst3 = 1'b0;
        d_req = 1'b0; f_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; f_addr = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        if (which) rst3 = 1'b1;
        else       rst1 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One complete single-requester transaction with cycle-exact checks.
    task automatic applyStimulus(input vec_t v, input int lat);
        sb_t e;
        d_req     = !v.isFetch;
        f_req     = v.isFetch;
        d_we      = v.we;
        d_addr    = v.isFetch ? ~v.addr : v.addr;
        f_addr    = v.isFetch ? v.addr : ~v.addr;
        d_wdata   = v.wdata;
        mem_rdata = v.memRdata;
        e.port    = v.isFetch;
        e.rdata   = v.expRdata;
        sbQueue.push_back(e);
        @(posedge clk); #1;
        checkOutput("acc_mem_e", smem_e, 1);
        checkOutput("acc_mem_addr", smem_addr, v.addr);
        checkOutput("acc_mem_we", smem_we, !v.isFetch && v.we);
        if (!v.isFetch && v.we) checkOutput("acc_mem_wdata", smem_wdata, v.wdata);
        checkOutput("acc_owner", sowner, v.isFetch);
        checkOutput("acc_busy", sbusy, 1);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk); #1;
            checkOutput("acc_hold_mem_e", smem_e, 1);
            checkOutput("acc_no_ack", {sd_ack, sf_ack}, 0);
        end
        @(posedge clk); #1;
        checkOutput("resp_acks", {sd_ack, sf_ack}, v.isFetch ? 2'b01 : 2'b10);
        checkOutput("resp_mem_e", smem_e, 0);
        checkOutput("resp_mem_we", smem_we, 0);
        checkOutput("resp_busy", sbusy, 1);
        d_req = 1'b0;
        f_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_acks", {sd_ack, sf_ack}, 0);
        checkOutput("idle_busy", sbusy, 0);
        checkOutput("idle_owner_held", sowner, v.isFetch);
    endtask

    // Watchdog so a wedged run still terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] order;
        sb_t        e;

        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 16'h1234};
        vecs[1] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, 16'h5A5A};
        vecs[2] = '{1'b0, 1'b1, 16'h00FE, 16'hBEEF, 16'h1111, 16'h5A5A};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hC0DE, 16'hC0DE};
        vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h2222, 16'h5A5A};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 16'h0F0F};

        // Reset state of the single-cycle instance.
        resetDut(1'b0);
        checkOutput("rst_mem_e", smem_e, 0);
        checkOutput("rst_mem_we", smem_we, 0);
        checkOutput("rst_mem_addr", smem_addr, 0);
        checkOutput("rst_mem_wdata", smem_wdata, 0);
        checkOutput("rst_acks", {sd_ack, sf_ack}, 0);
        checkOutput("rst_rdata", {sd_rdata, sf_rdata}, 0);
        checkOutput("rst_busy_owner", {sbusy, sowner}, 0);

        // Table of isolated transactions, back to back.
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 1);

        // Both requesters held high: data four times, then fetch forced.
        resetDut(1'b0);
        order = 10'b10_0001_0000;
        d_req = 1'b1; f_req = 1'b1; d_we = 1'b0;
        d_addr = 16'h0100; f_addr = 16'h0200; mem_rdata = 16'h7777;
        for (int i = 0; i < 10; i++) begin
            e.port = order[i];
            e.rdata = 16'h7777;
            sbQueue.push_back(e);
            @(posedge clk); #1;
            checkOutput("starve_owner", sowner, order[i]);
            checkOutput("starve_mem_addr", smem_addr, order[i] ? 16'h0200 : 16'h0100);
            @(posedge clk); #1;
            checkOutput("starve_ack", {sd_ack, sf_ack}, order[i] ? 2'b01 : 2'b10);
            @(posedge clk); #1;
            checkOutput("starve_ack_pulse", {sd_ack, sf_ack}, 0);
        end
        d_req = 1'b0; f_req = 1'b0;
        @(posedge clk); #1;

        // Three-cycle memory: read of 0xFFFF, data changing across ACCESS.
        resetDut(1'b1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFFFF; f_addr = 16'h0000;
        e.port = 1'b0; e.rdata = 16'hCCCC;
        sbQueue.push_back(e);
        @(posedge clk); #1;
        checkOutput("lat3_c1_busy_mem_e", {sbusy, smem_e}, 2'b11);
        checkOutput("lat3_c1_addr", smem_addr, 16'hFFFF);
        mem_rdata = 16'hAAAA;
        @(posedge clk); #1;
        checkOutput("lat3_c2_busy_mem_e", {sbusy, smem_e}, 2'b11);
        checkOutput("lat3_c2_no_ack", {sd_ack, sf_ack}, 0);
        mem_rdata = 16'hBBBB;
        @(posedge clk); #1;
        checkOutput("lat3_c3_busy_mem_e", {sbusy, smem_e}, 2'b11);
        checkOutput("lat3_c3_no_ack", {sd_ack, sf_ack}, 0);
        mem_rdata = 16'hCCCC;
        @(posedge clk); #1;
        checkOutput("lat3_c4_ack", {sd_ack, sf_ack}, 2'b10);
        checkOutput("lat3_c4_busy_mem_e", {sbusy, smem_e}, 2'b10);
        d_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("lat3_c5_busy", sbusy, 0);
        checkOutput("lat3_rdata_held", sd_rdata, 16'hCCCC);

        // Asynchronous reset in the middle of a three-cycle access.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1234; d_wdata = 16'h9999; mem_rdata = 16'h5555;
        @(posedge clk); #1;
        checkOutput("arst_pre_mem_e", smem_e, 1);
        @(posedge clk); #2;
        checkOutput("arst_pre_addr_we", {smem_we, smem_addr}, {1'b1, 16'h1234});
        rst3 = 1'b0;
        #1;
        checkOutput("arst_mem", {smem_e, smem_we, smem_addr, smem_wdata}, 0);
        checkOutput("arst_busy_owner", {sbusy, sowner}, 0);
        checkOutput("arst_rdata", {sd_rdata, sf_rdata}, 0);
        checkOutput("arst_acks", {sd_ack, sf_ack}, 0);
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #3;
        rst3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("arst_after_quiet", {sd_ack, sf_ack, sbusy}, 0);
        end

        // Fetch held one cycle past its ack is a fresh request.
        resetDut(1'b0);
        f_req = 1'b1; f_addr = 16'h0040; mem_rdata = 16'h4321;
        e.port = 1'b1; e.rdata = 16'h4321;
        sbQueue.push_back(e);
        @(posedge clk); #1;
        checkOutput("b2b_c1_mem_e", smem_e, 1);
        @(posedge clk); #1;
        checkOutput("b2b_c2_ack", {sd_ack, sf_ack}, 2'b01);
        mem_rdata = 16'h8765;
        e.rdata = 16'h8765;
        sbQueue.push_back(e);
        @(posedge clk); #1;
        checkOutput("b2b_c3_idle", {sf_ack, sbusy}, 0);
        @(posedge clk); #1;
        checkOutput("b2b_c4_regrant", {sbusy, smem_e}, 2'b11);
        checkOutput("b2b_c4_addr", smem_addr, 16'h0040);
        f_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("b2b_c5_ack", {sd_ack, sf_ack}, 2'b01);
        @(posedge clk); #1;
        checkOutput("b2b_c6_idle", {sf_ack, sbusy}, 0);

        checkOutput("sb_drained", sbQueue.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single unified memory port between two requesters: the data port (load/store, PC push) and the instruction-fetch port.
- Sits between the control unit / PC / register-file datapath and the memory unit.
- Replaces direct mux-driven memory address/enable selection with a request/acknowledge protocol.
- Applies fixed priority to data accesses, with an anti-starvation override for fetch.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 1, memory read latency in cycles (>=1); mem_rdata valid on the last ACCESS cycle
STARVE_LIM, 4, consecutive data grants with fetch pending before fetch is forced (>=1)

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous reset, active low
d_req  in  1  data-port request; held until d_ack
d_we  in  1  data-port write (1) / read (0); stable while d_req
d_addr  in  ADDR_W  data-port address
d_wdata  in  DATA_W  data-port write data
d_ack  out  1  one-cycle completion pulse, data port
d_rdata  out  DATA_W  read data; valid when d_ack=1 and d_we=0
f_req  in  1  fetch request; held until f_ack
f_addr  in  ADDR_W  fetch address
f_ack  out  1  one-cycle completion pulse, fetch port
f_rdata  out  DATA_W  fetched instruction; valid when f_ack=1
mem_e  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  1 when the state is not IDLE
owner  out  1  current/last grant owner: 0 = data, 1 = fetch

Behaviour:
- States: IDLE, ACCESS, RESP. Single clk, asynchronous active-low reset rst_b.
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs are 0: mem_* = 0, acks = 0, rdata regs = 0, owner = 0, busy = 0.
  - Starvation counter and latency counter are 0.
  - An in-flight access is abandoned and no ack is issued after reset release.
- IDLE, arbitration on the rising edge:
  - Neither req: stay in IDLE.
  - Only one req: grant it.
  - Both reqs: grant fetch if starve_cnt == STARVE_LIM, otherwise grant data.
  - On grant: latch addr, we (forced 0 for fetch) and wdata into mem_addr/mem_we/mem_wdata; set owner; load lat_cnt = MEM_LAT-1; go to ACCESS.
- Starvation counter:
  - Increments (saturating at STARVE_LIM) on each data grant while f_req = 1.
  - Clears on any fetch grant.
  - Unchanged otherwise.
- ACCESS:
  - mem_e = 1; mem_addr, mem_we and mem_wdata are held.
  - If lat_cnt != 0, decrement it.
  - If lat_cnt == 0: capture mem_rdata into the owner's rdata register (reads only; writes leave d_rdata unchanged) and go to RESP.
  - A write completes in MEM_LAT cycles identically; memory samples the write on the last ACCESS edge.
- RESP:
  - mem_e = 0 and mem_we = 0.
  - The owner's ack = 1 for exactly this cycle; the other ack stays 0.
  - Next state is IDLE unconditionally.
- Latency: a request first seen in IDLE at edge k produces ack high during cycle k+MEM_LAT+1. Minimum turnaround is MEM_LAT+2 cycles per access.
- Requester rule:
  - Deassert req on the edge that samples ack.
  - A req still high in the IDLE cycle after RESP is a new request. This permits back-to-back accesses with one idle cycle between them.
- Requests changing while not in IDLE are ignored; the latched values are used. A req dropped before ack is a protocol violation: the access still completes and the ack still pulses.
- rdata registers hold their last value between accesses.
- Addresses pass through unmodified: no alignment check, no wrap logic. 0xFFFF is a legal address.
- owner holds its last value in IDLE.

Test Plan:
1. Reset, then f_req=1, f_addr=0x0010, mem_rdata=0x1234 with MEM_LAT=1 -> mem_e=1 and mem_addr=0x0010 in cycle 1; f_ack=1 and f_rdata=0x1234 in cycle 2; d_ack stays 0.
2. d_req=1, d_we=1, d_addr=0x00FE, d_wdata=0xBEEF -> ACCESS cycle shows mem_we=1, mem_addr=0x00FE, mem_wdata=0xBEEF; d_ack pulses once; d_rdata unchanged.
3. d_req and f_req held high continuously, requesters re-requesting after each ack, STARVE_LIM=4 -> grant order D,D,D,D,F,D,D,D,D,F; owner matches; each ack is a one-cycle pulse.
4. MEM_LAT=3, d_req read at address 0xFFFF, mem_rdata changing each cycle (0xAAAA, 0xBBBB, 0xCCCC in ACCESS) -> 3 ACCESS cycles; d_rdata=0xCCCC at d_ack in cycle 4; busy=1 in cycles 1-4.
5. rst_b driven low during the 2nd ACCESS cycle (MEM_LAT=3) -> all outputs 0 immediately (asynchronous); after release with reqs low, no ack ever appears and state is IDLE.
6. Fetch completes, then f_req held high one cycle past f_ack -> a second fetch is granted from that IDLE cycle; f_ack pulses again 3 cycles later (MEM_LAT=1).
